// File: rtl/trig_sequencer.sv
// trig_sequencer: command FIFO of {N,S,W} feeding a timed single-cycle pulse-train FSM.
// Optional abort/flush path enabled by defining TRIG_SEQ_ABORT_EN.
module trig_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_trig,
  input  logic [31:0] I_trig_num,
  input  logic [31:0] I_trig_step,
  input  logic [31:0] I_wait,
  input  logic        I_abort,
  output logic        O_cmd_ready,
  output logic        O_pulse,
  output logic [31:0] O_idx,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_overflow,
  output logic        O_aborted
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_FIRE, S_DONE} state_t;

  logic [95:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ready_q, overflow_q;
  logic          abort, full, pop, push, drop;
  logic [31:0]   head_n, head_s, head_w, head_sp;

  state_t      state_q;
  logic [31:0] n_q, s_q, cnt_q, k_q, idx_q;
  logic        pulse_q, busy_q, done_q;

`ifdef TRIG_SEQ_ABORT_EN
  logic aborted_q;
  assign abort = I_abort;

  always_ff @(posedge I_clk) begin
    if (I_rst) aborted_q <= 1'b0;
    else       aborted_q <= I_abort;
  end
  assign O_aborted = aborted_q;
`else
  logic unused_abort;
  assign unused_abort = I_abort;
  assign abort        = 1'b0;
  assign O_aborted    = 1'b0;
`endif

  assign full    = (count_q == DEPTH_C);
  assign pop     = (state_q == S_IDLE) && (count_q != '0) && !abort;
  assign push    = I_trig && !abort && (!full || pop);
  assign drop    = I_trig && !abort && full && !pop;
  assign count_d = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

  assign {head_n, head_s, head_w} = mem_q[rd_ptr_q];
  assign head_sp = (head_s == 32'd0) ? 32'd1 : head_s;

  always_ff @(posedge I_clk) begin
    if (push) mem_q[wr_ptr_q] <= {I_trig_num, I_trig_step, I_wait};
  end

  always_ff @(posedge I_clk) begin
    if (I_rst || abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      ready_q <= (count_d != DEPTH_C);
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst)     overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  // The head entry is decoded in the pop cycle so a zero wait fires on the very next cycle.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      n_q     <= 32'd0;
      s_q     <= 32'd0;
      cnt_q   <= 32'd0;
      k_q     <= 32'd0;
      idx_q   <= 32'd0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pulse_q <= 1'b0;
          done_q  <= 1'b0;
          if (pop) begin
            n_q    <= head_n;
            s_q    <= head_sp;
            k_q    <= 32'd0;
            busy_q <= 1'b1;
            if (head_n == 32'd0) begin
              state_q <= S_LOAD;
            end else if (head_w == 32'd0) begin
              state_q <= S_FIRE;
              pulse_q <= 1'b1;
              idx_q   <= 32'd0;
              cnt_q   <= head_sp - 32'd1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= head_w - 32'd1;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_LOAD: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_WAIT: begin
          if (cnt_q == 32'd0) begin
            state_q <= S_FIRE;
            pulse_q <= 1'b1;
            idx_q   <= 32'd0;
            k_q     <= 32'd0;
            cnt_q   <= s_q - 32'd1;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        // cnt_q counts the gap cycles left before the next pulse.
        S_FIRE: begin
          if (pulse_q && (k_q == n_q - 32'd1)) begin
            state_q <= S_DONE;
            pulse_q <= 1'b0;
            done_q  <= 1'b1;
          end else if (cnt_q == 32'd0) begin
            pulse_q <= 1'b1;
            k_q     <= k_q + 32'd1;
            idx_q   <= k_q + 32'd1;
            cnt_q   <= s_q - 32'd1;
          end else begin
            pulse_q <= 1'b0;
            cnt_q   <= cnt_q - 32'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign O_cmd_ready = ready_q;
  assign O_overflow  = overflow_q;
  assign O_pulse     = pulse_q;
  assign O_idx       = idx_q;
  assign O_busy      = busy_q;
  assign O_done      = done_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer: pulse timing, FIFO overflow/ready, reset and abort behaviour.
module tb_trig_sequencer;

  logic        I_clk, I_rst, I_trig, I_abort;
  logic [31:0] I_trig_num, I_trig_step, I_wait;
  logic        O_cmd_ready, O_pulse, O_busy, O_done, O_overflow, O_aborted;
  logic [31:0] O_idx;

  trig_sequencer #(.FIFO_DEPTH(4)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_trig(I_trig), .I_trig_num(I_trig_num),
    .I_trig_step(I_trig_step), .I_wait(I_wait), .I_abort(I_abort),
    .O_cmd_ready(O_cmd_ready), .O_pulse(O_pulse), .O_idx(O_idx), .O_busy(O_busy),
    .O_done(O_done), .O_overflow(O_overflow), .O_aborted(O_aborted)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int pulse_cyc[$], pulse_idx[$], done_cyc[$], abort_cyc[$];
  int exp_pc[$], exp_pi[$], exp_dc[$];
  int busy_first, busy_last;
  logic rdy_log [0:127];
  logic ovf_log [0:127];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the middle of the next cycle and log what the DUT shows there.
  task automatic step();
    @(negedge I_clk);
    cyc++;
    if (O_pulse) begin
      pulse_cyc.push_back(cyc);
      pulse_idx.push_back(int'(O_idx));
    end
    if (O_done)    done_cyc.push_back(cyc);
    if (O_aborted) abort_cyc.push_back(cyc);
    if (O_busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (cyc < 128) begin
      rdy_log[cyc] = O_cmd_ready;
      ovf_log[cyc] = O_overflow;
    end
  endtask

  task automatic clear_log();
    cyc = 0;
    pulse_cyc.delete(); pulse_idx.delete(); done_cyc.delete(); abort_cyc.delete();
    exp_pc.delete(); exp_pi.delete(); exp_dc.delete();
    busy_first = -1;
    busy_last  = -1;
  endtask

  task automatic exp_pulse(input int c, input int i);
    exp_pc.push_back(c);
    exp_pi.push_back(i);
  endtask

  task automatic cmd(input logic t, input int n, input int s, input int w);
    I_trig      = t;
    I_trig_num  = n;
    I_trig_step = s;
    I_wait      = w;
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  task automatic do_reset();
    I_rst = 1'b1;
    cmd(1'b0, 0, 0, 0);
    I_abort = 1'b0;
    step();
    step();
    I_rst = 1'b0;
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_npulse"}, pulse_cyc.size(), exp_pc.size());
    for (int i = 0; i < exp_pc.size() && i < pulse_cyc.size(); i++) begin
      check_eq($sformatf("%s_pcyc%0d", tag, i), pulse_cyc[i], exp_pc[i]);
      check_eq($sformatf("%s_pidx%0d", tag, i), pulse_idx[i], exp_pi[i]);
    end
    check_eq({tag, "_ndone"}, done_cyc.size(), exp_dc.size());
    for (int i = 0; i < exp_dc.size() && i < done_cyc.size(); i++)
      check_eq($sformatf("%s_dcyc%0d", tag, i), done_cyc[i], exp_dc[i]);
  endtask

  initial begin
    I_rst = 1'b0;
    I_abort = 1'b0;
    cmd(1'b0, 0, 0, 0);
    clear_log();

    // Reset values
    do_reset();
    check_eq("rst_ready", O_cmd_ready, 1);
    check_eq("rst_pulse", O_pulse, 0);
    check_eq("rst_idx", O_idx, 0);
    check_eq("rst_busy", O_busy, 0);
    check_eq("rst_done", O_done, 0);
    check_eq("rst_ovf", O_overflow, 0);
    check_eq("rst_abt", O_aborted, 0);

    // N=3 S=4 W=5
    clear_log();
    cmd(1'b1, 3, 4, 5);
    step();
    cmd(1'b0, 0, 0, 0);
    run_to(25);
    exp_pulse(7, 0); exp_pulse(11, 1); exp_pulse(15, 2);
    exp_dc.push_back(16);
    check_log("t1");
    check_eq("t1_busy_first", busy_first, 2);
    check_eq("t1_busy_last", busy_last, 16);
    check_eq("t1_idx_hold", O_idx, 2);

    // N=4 S=0 W=0 back-to-back
    do_reset();
    clear_log();
    cmd(1'b1, 4, 0, 0);
    step();
    cmd(1'b0, 0, 0, 0);
    run_to(12);
    for (int i = 0; i < 4; i++) exp_pulse(2 + i, i);
    exp_dc.push_back(6);
    check_log("t2");

    // N=0 W=100
    do_reset();
    clear_log();
    cmd(1'b1, 0, 7, 100);
    step();
    cmd(1'b0, 0, 0, 0);
    run_to(12);
    exp_dc.push_back(3);
    check_log("t3");
    check_eq("t3_busy_last", busy_last, 3);

    // Overflow: long X, then five triggers while X waits
    do_reset();
    clear_log();
    cmd(1'b1, 1, 1, 20);
    for (int c = 1; c <= 50; c++) begin
      step();
      if (c >= 3 && c <= 7) cmd(1'b1, c - 2, 0, 0);
      else                  cmd(1'b0, 0, 0, 0);
    end
    exp_pulse(22, 0); exp_pulse(25, 0);
    exp_pulse(28, 0); exp_pulse(29, 1);
    exp_pulse(32, 0); exp_pulse(33, 1); exp_pulse(34, 2);
    exp_pulse(37, 0); exp_pulse(38, 1); exp_pulse(39, 2); exp_pulse(40, 3);
    exp_dc.push_back(23); exp_dc.push_back(26); exp_dc.push_back(30);
    exp_dc.push_back(35); exp_dc.push_back(41);
    check_log("t4");
    check_eq("t4_rdy6", rdy_log[6], 1);
    check_eq("t4_rdy7", rdy_log[7], 0);
    check_eq("t4_rdy24", rdy_log[24], 0);
    check_eq("t4_rdy25", rdy_log[25], 1);
    check_eq("t4_ovf7", ovf_log[7], 0);
    check_eq("t4_ovf8", ovf_log[8], 1);
    check_eq("t4_ovf_sticky", O_overflow, 1);
    do_reset();
    check_eq("t4_ovf_cleared", O_overflow, 0);

    // Push with pop while full
    clear_log();
    cmd(1'b1, 1, 0, 10);
    for (int c = 1; c <= 35; c++) begin
      step();
      if (c >= 1 && c <= 4) cmd(1'b1, 1, 0, 0);
      else if (c == 14)     cmd(1'b1, 2, 0, 0);
      else                  cmd(1'b0, 0, 0, 0);
    end
    exp_pulse(12, 0); exp_pulse(15, 0); exp_pulse(18, 0); exp_pulse(21, 0);
    exp_pulse(24, 0); exp_pulse(27, 0); exp_pulse(28, 1);
    exp_dc.push_back(13); exp_dc.push_back(16); exp_dc.push_back(19);
    exp_dc.push_back(22); exp_dc.push_back(25); exp_dc.push_back(29);
    check_log("t5");
    check_eq("t5_rdy4", rdy_log[4], 1);
    check_eq("t5_rdy5", rdy_log[5], 0);
    check_eq("t5_rdy15", rdy_log[15], 0);
    check_eq("t5_rdy18", rdy_log[18], 1);
    check_eq("t5_ovf", O_overflow, 0);

    // Abort during WAIT with two commands queued
    do_reset();
    clear_log();
    cmd(1'b1, 2, 3, 10);
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c <= 2) cmd(1'b1, 1, 0, 0);
      else        cmd(1'b0, 0, 0, 0);
      I_abort = (c == 5);
    end
`ifdef TRIG_SEQ_ABORT_EN
    check_eq("t6_nabort", abort_cyc.size(), 1);
    if (abort_cyc.size() > 0) check_eq("t6_abort_cyc", abort_cyc[0], 6);
    check_eq("t6_busy_last", busy_last, 5);
    check_eq("t6_rdy6", rdy_log[6], 1);
`else
    exp_pulse(12, 0); exp_pulse(15, 1); exp_pulse(18, 0); exp_pulse(21, 0);
    exp_dc.push_back(16); exp_dc.push_back(19); exp_dc.push_back(22);
    check_eq("t6_nabort", abort_cyc.size(), 0);
`endif
    check_log("t6");

    // Abort coinciding with a trigger while idle
    do_reset();
    clear_log();
    cmd(1'b1, 1, 0, 0);
    I_abort = 1'b1;
    step();
    cmd(1'b0, 0, 0, 0);
    I_abort = 1'b0;
    run_to(10);
`ifdef TRIG_SEQ_ABORT_EN
    check_eq("t7_nabort", abort_cyc.size(), 1);
    if (abort_cyc.size() > 0) check_eq("t7_abort_cyc", abort_cyc[0], 1);
`else
    exp_pulse(2, 0);
    exp_dc.push_back(3);
    check_eq("t7_nabort", abort_cyc.size(), 0);
`endif
    check_log("t7");
    check_eq("t7_ovf", O_overflow, 0);

    // Reset in the middle of a train with one command queued
    do_reset();
    clear_log();
    cmd(1'b1, 5, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) cmd(1'b1, 1, 0, 0);
      else        cmd(1'b0, 0, 0, 0);
      I_rst = (c == 4);
    end
    exp_pulse(2, 0); exp_pulse(3, 1); exp_pulse(4, 2);
    check_log("t8");
    check_eq("t8_busy_last", busy_last, 4);
    check_eq("t8_rdy5", rdy_log[5], 1);
    check_eq("t8_idx", O_idx, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trig_sequencer.md
# trig_sequencer

Trigger sequencer on the read-clock side of the ISA decode path. Accepts decoded trigger commands (pulse count, interval, initial wait) into a small command FIFO and plays each one out as a timed train of single-cycle trigger pulses for the acquisition/AQTC logic. It also reports per-pulse index, completion and overflow status.

## Interface
Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.

Ports:
- I_clk  in  1  clock; same domain as the decoder's read clock.
- I_rst  in  1  reset; synchronous, active-high.
- I_trig  in  1  command strobe; one cycle per command.
- I_trig_num  in  32  number of pulses N, sampled with I_trig.
- I_trig_step  in  32  pulse interval S in cycles, sampled with I_trig.
- I_wait  in  32  initial delay W in cycles, sampled with I_trig.
- I_abort  in  1  abort request (see Configuration).
- O_cmd_ready  out  1  FIFO not full.
- O_pulse  out  1  trigger pulse, one cycle wide.
- O_idx  out  32  index 0..N-1 of current pulse; valid with O_pulse, holds last value otherwise.
- O_busy  out  1  command in progress (states LOAD/WAIT/FIRE/DONE).
- O_done  out  1  one-cycle pulse after the last pulse of a command.
- O_overflow  out  1  sticky: a command was dropped.
- O_aborted  out  1  one-cycle abort acknowledge.

## Operation
- Command FIFO: stores {N,S,W} (96 bits). Push on I_trig when not full. Push while full with no pop in the same cycle drops the command and sets O_overflow; O_overflow stays set until reset. Push and pop in the same cycle while full: both are accepted.
- FSM states: IDLE, LOAD, WAIT, FIRE, DONE.
  - IDLE: FIFO non-empty → pop, register N/S/W → LOAD.
  - LOAD:
    - N==0 → DONE (no pulses).
    - W==0 → FIRE.
    - Otherwise → WAIT with the wait counter set to W-1.
  - WAIT: decrement; at 0 → FIRE.
  - FIRE: O_pulse=1, O_idx=k.
    - k==N-1 → DONE.
    - Otherwise → FIRE again after S'-1 gap cycles, with S'=max(S,1). S=0 gives back-to-back pulses.
  - DONE: O_done=1 → IDLE.
- Counters: 32-bit unsigned, no wrap. N=0xFFFFFFFF must run to completion.
- Reset values: all outputs 0 except O_cmd_ready=1; state IDLE; FIFO empty; O_overflow cleared.
- Reset mid-command: the train stops immediately with no O_done, and the FIFO is flushed.

## Timing
- Cycle 0 = I_trig accepted into an empty FIFO while IDLE:
  - Pulse k at cycle 2+W+k·S'.
  - O_done at cycle 3+W+(N-1)·S'.
  - For N=0, O_done at cycle 3.
- Queued commands: state is IDLE the cycle after O_done. The next command's first pulse is at done+2+W.
- O_cmd_ready deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the pop.
- O_busy is high from LOAD through DONE inclusive.

## Configuration
- TRIG_SEQ_ABORT_EN defined:
  - I_abort high in any cycle → next cycle state IDLE, FIFO flushed, O_pulse low, O_aborted=1 for one cycle, no O_done.
  - An I_trig coinciding with I_abort is dropped; O_overflow is not set by this.
  - I_abort while IDLE with an empty FIFO still produces O_aborted.
- TRIG_SEQ_ABORT_EN undefined: I_abort is ignored and O_aborted is tied 0.

## Test plan
- Single command N=3, S=4, W=5 at cycle 0 → O_pulse at cycles 7, 11, 15 with O_idx 0, 1, 2; O_done at 16; O_busy high cycles 2–16.
- N=4, S=0, W=0 → pulses at cycles 2, 3, 4, 5 back-to-back; O_done at 6.
- N=0, W=100 → no pulse; O_done at cycle 3.
- Five I_trig back-to-back with FIFO_DEPTH=4 while the first command is still running → fifth command dropped; O_overflow=1 sticky; the four accepted commands play in order.
- Push on the same cycle as a pop with the FIFO full → command accepted, no overflow.
- With TRIG_SEQ_ABORT_EN: abort during the WAIT of command N=2, W=10 with two more queued → O_aborted next cycle, no pulses, no O_done, FIFO empty, O_cmd_ready=1. Without the macro, the same stimulus runs all three commands to completion.
